// File: rtl/somador_subtrator_serial.sv
// somador_subtrator_serial
// Bit-serial (STEP bits per clock) unsigned adder/subtractor with
// valid/ready handshakes on both the operand and result sides.
//
// Parameters:
//   WIDTH  operand width (>= 2)
//   STEP   bits processed per clock (WIDTH % STEP must be 0)
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   unit idle, operands accepted on in_valid && in_ready
//   A, B       operands
//   M          0 = A+B, 1 = A-B
//   out_valid  result valid
//   out_ready  consumer accepts result
//   resultado  WIDTH+1 bit result, bit WIDTH = carry (add) / borrow (sub)
//   ovf        signed overflow, only when SOMSUB_OVF_EN is defined
//
// Optional feature macro: SOMSUB_OVF_EN
module somador_subtrator_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SOMSUB_OVF_EN
    output logic [WIDTH:0]   resultado,
    output logic             ovf
`else
    output logic [WIDTH:0]   resultado
`endif
);

    generate
        if (WIDTH < 2 || STEP == 0 || (WIDTH % STEP) != 0) begin : g_param_check
            $error("somador_subtrator_serial: need WIDTH >= 2 and WIDTH %% STEP == 0");
        end
    endgenerate

    localparam int unsigned N  = WIDTH / STEP;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    estado_t          state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, part, part_nx;
    logic             carry, m_r;
    logic [CW-1:0]    count;
    logic             last;
    logic [STEP:0]    soma;

    assign in_ready  = (state == OCIOSO);
    assign out_valid = (state == PRONTO);
    assign last      = (count == CW'(N - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= OCIOSO;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            OCIOSO:  if (in_valid)  state_nx = CALCULA;
            CALCULA: if (last)      state_nx = PRONTO;
            PRONTO:  if (out_ready) state_nx = OCIOSO;
            default:                state_nx = OCIOSO;
        endcase
    end

    // One STEP-wide slice of the ripple sum; the slice enters the partial
    // register from the top so that after N steps the LSB slice sits at bit 0.
    always_comb begin
        soma    = {1'b0, a_sr[STEP-1:0]} + {1'b0, b_sr[STEP-1:0]} + (STEP+1)'(carry);
        part_nx = (part >> STEP) | (WIDTH'(soma[STEP-1:0]) << (WIDTH - STEP));
    end

`ifdef SOMSUB_OVF_EN
    logic ovf_r;
    logic c_msb_in;
    // Carry into the slice MSB recovered from its sum bit and its inputs.
    assign c_msb_in = a_sr[STEP-1] ^ b_sr[STEP-1] ^ soma[STEP-1];
    assign ovf      = ovf_r;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            part      <= '0;
            carry     <= 1'b0;
            m_r       <= 1'b0;
            count     <= '0;
            resultado <= '0;
`ifdef SOMSUB_OVF_EN
            ovf_r     <= 1'b0;
`endif
        end else begin
            case (state)
                OCIOSO: begin
                    if (in_valid) begin
                        a_sr  <= A;
                        b_sr  <= B ^ {WIDTH{M}};
                        carry <= M;
                        m_r   <= M;
                        count <= '0;
                    end
                end
                CALCULA: begin
                    a_sr  <= a_sr >> STEP;
                    b_sr  <= b_sr >> STEP;
                    part  <= part_nx;
                    carry <= soma[STEP];
                    count <= count + 1'b1;
                    if (last) begin
                        resultado <= {m_r ^ soma[STEP], part_nx};
`ifdef SOMSUB_OVF_EN
                        ovf_r     <= c_msb_in ^ soma[STEP];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Self-checking bench for somador_subtrator_serial: one instance with
// STEP=1 and one with STEP=4 (WIDTH=8), selected by 'sel'.
module tb_somador_subtrator_serial;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int unsigned sel;
    logic        iv, ordy, m;
    logic [7:0]  a, b;

    logic       iv1, iv4, or1, or4, ir1, ir4, ov1, ov4;
    logic [8:0] res1, res4;
    logic       ir, ov, ovfm;
    logic [8:0] res;

    int checks = 0;
    int errors = 0;

    assign iv1 = (sel == 1) ? iv   : 1'b0;
    assign iv4 = (sel == 4) ? iv   : 1'b0;
    assign or1 = (sel == 1) ? ordy : 1'b1;
    assign or4 = (sel == 4) ? ordy : 1'b1;
    assign ir  = (sel == 4) ? ir4  : ir1;
    assign ov  = (sel == 4) ? ov4  : ov1;
    assign res = (sel == 4) ? res4 : res1;

`ifdef SOMSUB_OVF_EN
    logic ovf1, ovf4;
    assign ovfm = (sel == 4) ? ovf4 : ovf1;
`else
    assign ovfm = 1'b0;
`endif

    somador_subtrator_serial #(.WIDTH(8), .STEP(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1),
        .A(a), .B(b), .M(m), .out_valid(ov1), .out_ready(or1),
`ifdef SOMSUB_OVF_EN
        .ovf(ovf1),
`endif
        .resultado(res1)
    );

    somador_subtrator_serial #(.WIDTH(8), .STEP(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4),
        .A(a), .B(b), .M(m), .out_valid(ov4), .out_ready(or4),
`ifdef SOMSUB_OVF_EN
        .ovf(ovf4),
`endif
        .resultado(res4)
    );

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y, input logic mm);
        int e;
        e = mm ? (int'(x) - int'(y)) : (int'(x) + int'(y));
        return 9'(e & 511);
    endfunction

    function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic mm);
        int sx, sy, e;
        sx = int'($signed(x));
        sy = int'($signed(y));
        e  = mm ? (sx - sy) : (sx + sy);
        return (e > 127) || (e < -128);
    endfunction

    // One complete transaction. 'hold' cycles of out_ready=0 after out_valid,
    // during which fresh operands are driven with in_valid high.
    task automatic do_op(input int unsigned s, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic m_i, input int unsigned hold,
                         output logic [8:0] r_o, output logic f_o, output int unsigned lat);
        logic [8:0] prev;
        @(negedge clock);
        sel = s; iv = 1'b1; a = a_i; b = b_i; m = m_i; ordy = (hold == 0);
        #1;
        checks++;
        if (ir !== 1'b1) begin
            errors++; $display("FAIL in_ready_before_accept: got %b expected 1", ir);
        end
        prev = res;
        @(posedge clock); #1;
        iv = 1'b0; a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (ov === 1'b1) begin
                lat = k;
                break;
            end
            checks++;
            if (res !== prev) begin
                errors++; $display("FAIL result_held_during_calc: got %h expected %h", res, prev);
            end
        end
        checks++;
        if (lat == 0) begin
            errors++; $display("FAIL out_valid_timeout: got none expected within 40 cycles");
        end
        r_o = res;
        f_o = ovfm;
        for (int h = 0; h < int'(hold); h++) begin
            @(negedge clock);
            iv = 1'b1; a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
            @(posedge clock); #1;
            checks++;
            if (res !== r_o) begin
                errors++; $display("FAIL backpressure_result: got %h expected %h", res, r_o);
            end
            checks++;
            if (ir !== 1'b0 || ov !== 1'b1) begin
                errors++; $display("FAIL backpressure_flags: got ir=%b ov=%b expected ir=0 ov=1", ir, ov);
            end
            checks++;
            if (ovfm !== f_o) begin
                errors++; $display("FAIL backpressure_ovf: got %b expected %b", ovfm, f_o);
            end
        end
        @(negedge clock);
        iv = 1'b0; ordy = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            errors++; $display("FAIL in_ready_after_handshake: got ir=%b ov=%b expected ir=1 ov=0", ir, ov);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; m = 1'b0; sel = 1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (ir1 !== 1'b1 || ir4 !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b%b expected 11", ir1, ir4);
        end
        checks++;
        if (ov1 !== 1'b0 || ov4 !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b%b expected 00", ov1, ov4);
        end
        checks++;
        if (res1 !== 9'h000 || res4 !== 9'h000) begin
            errors++; $display("FAIL reset_resultado: got %h/%h expected 000/000", res1, res4);
        end
`ifdef SOMSUB_OVF_EN
        checks++;
        if (ovf1 !== 1'b0 || ovf4 !== 1'b0) begin
            errors++; $display("FAIL reset_ovf: got %b%b expected 00", ovf1, ovf4);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [8:0] r; logic f; int unsigned lat;
        do_op(1, 8'd200, 8'd100, 1'b0, 0, r, f, lat);
        checks++;
        if (r !== 9'h12C) begin errors++; $display("FAIL s1_200p100: got %h expected 12c", r); end
        checks++;
        if (lat != 8) begin errors++; $display("FAIL s1_latency: got %0d expected 8", lat); end

        do_op(1, 8'd100, 8'd200, 1'b1, 0, r, f, lat);
        checks++;
        if (r !== 9'h19C) begin errors++; $display("FAIL s1_100m200: got %h expected 19c", r); end

        do_op(4, 8'd0, 8'd0, 1'b1, 0, r, f, lat);
        checks++;
        if (r !== 9'h000) begin errors++; $display("FAIL s4_0m0: got %h expected 000", r); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL s4_latency: got %0d expected 2", lat); end

        do_op(4, 8'h7F, 8'h01, 1'b0, 0, r, f, lat);
        checks++;
        if (r !== 9'h080) begin errors++; $display("FAIL s4_7fp01: got %h expected 080", r); end
`ifdef SOMSUB_OVF_EN
        checks++;
        if (f !== 1'b1) begin errors++; $display("FAIL s4_ovf_7fp01: got %b expected 1", f); end
`endif
        do_op(4, 8'h05, 8'h03, 1'b0, 0, r, f, lat);
        checks++;
        if (r !== 9'h008) begin errors++; $display("FAIL s4_05p03: got %h expected 008", r); end
`ifdef SOMSUB_OVF_EN
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL s4_ovf_05p03: got %b expected 0", f); end
`endif
    endtask

    task automatic test_backpressure();
        logic [8:0] r; logic f; int unsigned lat;
        do_op(1, 8'd37, 8'd250, 1'b0, 5, r, f, lat);
        checks++;
        if (r !== ref_sum(8'd37, 8'd250, 1'b0)) begin
            errors++; $display("FAIL bp_result: got %h expected %h", r, ref_sum(8'd37, 8'd250, 1'b0));
        end
        do_op(4, 8'd9, 8'd20, 1'b1, 5, r, f, lat);
        checks++;
        if (r !== ref_sum(8'd9, 8'd20, 1'b1)) begin
            errors++; $display("FAIL bp_result4: got %h expected %h", r, ref_sum(8'd9, 8'd20, 1'b1));
        end
    endtask

    task automatic test_random();
        logic [8:0] r; logic f; int unsigned lat, s, hold;
        logic [7:0] x, y; logic mm;
        for (int i = 0; i < 40; i++) begin
            s    = (i % 2 == 0) ? 1 : 4;
            x    = 8'($urandom);
            y    = 8'($urandom);
            mm   = 1'($urandom);
            hold = $urandom_range(0, 2);
            do_op(s, x, y, mm, hold, r, f, lat);
            checks++;
            if (r !== ref_sum(x, y, mm)) begin
                errors++; $display("FAIL rand_result: s=%0d a=%h b=%h m=%b got %h expected %h", s, x, y, mm, r, ref_sum(x, y, mm));
            end
            checks++;
            if (lat != 8 / s) begin
                errors++; $display("FAIL rand_latency: s=%0d got %0d expected %0d", s, lat, 8 / s);
            end
`ifdef SOMSUB_OVF_EN
            checks++;
            if (f !== ref_ovf(x, y, mm)) begin
                errors++; $display("FAIL rand_ovf: a=%h b=%h m=%b got %b expected %b", x, y, mm, f, ref_ovf(x, y, mm));
            end
`else
            if (ref_ovf(x, y, mm) === 1'bx) $display("ovf model undefined");
`endif
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [8:0] r; logic f; int unsigned lat;
        @(negedge clock);
        sel = 1; iv = 1'b1; a = 8'd55; b = 8'd66; m = 1'b0; ordy = 1'b1;
        @(posedge clock); #1;
        iv = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b0) begin
            errors++; $display("FAIL reset_mid_flags: got ir=%b ov=%b expected ir=1 ov=0", ir1, ov1);
        end
        checks++;
        if (res1 !== 9'h000) begin
            errors++; $display("FAIL reset_mid_resultado: got %h expected 000", res1);
        end
        @(negedge clock);
        reset_n = 1'b1;
        do_op(1, 8'd200, 8'd100, 1'b0, 0, r, f, lat);
        checks++;
        if (r !== 9'h12C) begin errors++; $display("FAIL after_reset_op: got %h expected 12c", r); end
        checks++;
        if (lat != 8) begin errors++; $display("FAIL after_reset_latency: got %0d expected 8", lat); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_random();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
